neuron_seq: RTL
===============

NEURON_SEQ -- requirements
Module: neuron_seq

Interface
REQ-001 SHALL have parameter N_IN, default 8, meaning number of inputs per neuron evaluation (legal range 1..64).
REQ-002 SHALL have parameter FRAC, default 6, meaning fractional bits of the signed 8-bit fixed-point format (Q1.6).
REQ-003 SHALL have parameter RELU, default 0, meaning that when 1, negative results are clamped to 0.
REQ-004 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port cfg_we  input  1  configuration write strobe.
REQ-007 SHALL have port cfg_bias  input  1  when 1, the write targets the bias register; when 0, it targets weight[cfg_addr].
REQ-008 SHALL have port cfg_addr  input  clog2(N_IN) (min 1)  weight index.
REQ-009 SHALL have port cfg_data  input  8  signed Q1.6 weight or bias value.
REQ-010 SHALL have port cfg_err  output  1  one-cycle pulse when a configuration write is rejected.
REQ-011 SHALL have port in_valid  input  1  input sample valid.
REQ-012 SHALL have port in_data  input  8  signed Q1.6 input sample x.
REQ-013 SHALL have port in_ready  output  1  block can accept a sample.
REQ-014 SHALL have port out_valid  output  1  result valid.
REQ-015 SHALL have port out_data  output  8  signed Q1.6 neuron result.
REQ-016 SHALL have port out_ovf  output  1  the result was saturated; valid with out_valid.
REQ-017 SHALL have port out_ready  input  1  consumer accepts the result.

Function
REQ-018 SHALL implement the states IDLE, ACC, FIN and OUT, with sample counter cnt (0..N_IN-1) and signed accumulator acc of width 16+clog2(N_IN).
REQ-019 SHALL drive in_ready=1 in IDLE and ACC and 0 in FIN and OUT; a sample is accepted on in_valid&in_ready.
REQ-020 SHALL, on acceptance in IDLE: set acc = weight[0]*x (signed 16-bit product, sign-extended); set cnt=1; go to ACC, or to FIN if N_IN=1.
REQ-021 SHALL, on acceptance in ACC: set acc += weight[cnt]*x; increment cnt; go to FIN when the accepted sample is number N_IN-1.
REQ-022 SHALL hold acc and cnt unchanged in ACC when in_valid=0; there is no timeout.
REQ-023 SHALL, in FIN (one cycle): compute r = (acc >>> FRAC) + sign-extended bias; saturate r to [-128,127], setting out_ovf if clamped; apply ReLU if enabled (ReLU alone does not set out_ovf); register the result into out_data/out_ovf; go to OUT.
REQ-024 SHALL, in OUT: hold out_valid=1 and out_data/out_ovf stable until out_ready=1, then go to IDLE with cnt=0 on the same edge.
REQ-025 SHALL have a latency of two cycles: with the last sample accepted at edge T, out_valid=1 after edge T+2.
REQ-026 SHALL use truncation toward negative infinity (arithmetic shift); there is no rounding.
REQ-027 SHALL apply configuration writes only in IDLE; a write in IDLE takes effect from the next cycle, so a sample accepted in the same cycle uses the old weight[0].
REQ-028 SHALL ignore a cfg_we in ACC/FIN/OUT and pulse cfg_err for one cycle; it SHALL also reject a cfg_addr >= N_IN in any state.
REQ-029 SHALL retain weights and bias across evaluations until rewritten or reset.

Reset
REQ-030 SHALL, on rst=1 at a rising edge: set state=IDLE, cnt=0, acc=0, all weights and bias to 0, and out_valid, out_data, out_ovf and cfg_err to 0; in_ready SHALL be 1 after the reset edge.
REQ-031 SHALL give reset priority over all concurrent events; a partial sum or pending result is discarded without being output.

Verification
REQ-032 SHALL verify the basic sum: N_IN=8, all weights 0x40 (1.0), bias 0x00, eight samples 0x08 (0.125) -> out_data=0x40, out_ovf=0, out_valid two cycles after the last accept.
REQ-033 SHALL verify saturation: weights 0xC0 (-1.0), samples 0x40, bias 0x00 -> out_data=0x80, out_ovf=1; with RELU=1 -> out_data=0x00, out_ovf=1.
REQ-034 SHALL verify bias and backpressure: bias 0x10, weights 0x40, samples 0x00; out_ready low for 5 cycles -> out_data=0x10 held stable, in_ready=0 throughout; IDLE follows the cycle after out_ready=1.
REQ-035 SHALL verify a rejected config write: cfg_we with weight[2]=0x7F after 3 samples accepted -> cfg_err pulses once, the result uses the old weight[2], and the same write in IDLE succeeds.
REQ-036 SHALL verify reset mid-operation: rst after 4 samples accepted -> no out_valid; a subsequent full 8-sample run with zero weights yields 0x00.
REQ-037 SHALL verify gapped input: in_valid deasserted for random cycles between samples -> the result is identical to the result of the back-to-back run.

Source files
------------

// File: rtl/neuron_seq.sv
// neuron_seq: single fixed-point neuron. Multiplies N_IN signed Q1.6 samples by
// stored Q1.6 weights, accumulates, rescales, adds a bias, saturates to 8 bits
// and optionally applies ReLU.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   cfg_we/cfg_bias      config write strobe; target is the bias (1) or weight[cfg_addr] (0)
//   cfg_addr, cfg_data   weight index and signed Q1.6 value
//   cfg_err              one-cycle pulse when a config write is rejected
//   in_valid/in_ready    sample handshake, in_data signed Q1.6
//   out_valid/out_ready  result handshake, out_data signed Q1.6, out_ovf saturation flag
//
// state | meaning
// IDLE  | waiting for the first sample; config writes allowed
// ACC   | accumulating samples 1..N_IN-1
// FIN   | rescale, add bias, saturate, register result
// OUT   | presenting result until out_ready
module neuron_seq #(
   parameter int N_IN = 8,
   parameter int FRAC = 6,
   parameter int RELU = 0,
   localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_we,
   input  logic          cfg_bias,
   input  logic [AW-1:0] cfg_addr,
   input  logic [7:0]    cfg_data,
   output logic          cfg_err,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   output logic          out_valid,
   output logic [7:0]    out_data,
   output logic          out_ovf,
   input  logic          out_ready
);

   localparam int ACCW = 16 + $clog2(N_IN);

   typedef enum logic [1:0] {IDLE, ACC, FIN, OUT} state_t;

   state_t state, state_nx;

   logic signed [7:0]      weight [N_IN];
   logic signed [7:0]      bias;
   logic signed [ACCW-1:0] acc;
   logic [AW-1:0]          cnt;

   logic                   accept;
   logic                   last;
   logic                   cfg_ok;
   logic                   addr_bad;
   logic signed [15:0]     prod;
   logic signed [ACCW-1:0] prod_ext;
   logic signed [ACCW:0]   r_full;
   logic signed [7:0]      r_sat;
   logic                   r_ovf;
   logic signed [7:0]      r_fin;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (accept) state_nx = (N_IN == 1) ? FIN : ACC;
         ACC:  if (accept && last) state_nx = FIN;
         FIN:  state_nx = OUT;
         OUT:  if (out_valid && out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // outputs decoded from state
   always_comb begin
      in_ready = (state == IDLE) || (state == ACC);
   end

   assign accept   = in_valid && in_ready;
   assign last     = (32'(cnt) == N_IN - 1);
   // cnt is 0 in IDLE, so the same index serves the first product
   assign prod     = weight[cnt] * $signed(in_data);
   assign prod_ext = ACCW'(prod);

   // the address only matters for weight writes
   assign addr_bad = !cfg_bias && (32'(cfg_addr) >= N_IN);
   assign cfg_ok   = cfg_we && (state == IDLE) && !addr_bad;

   // one bit of headroom so the bias add cannot wrap before saturation
   assign r_full = (ACCW+1)'(acc >>> FRAC) + (ACCW+1)'(bias);

   always_comb begin
      r_sat = r_full[7:0];
      r_ovf = 1'b0;
      if (r_full > 127) begin
         r_sat = 8'sd127;
         r_ovf = 1'b1;
      end else if (r_full < -128) begin
         r_sat = -8'sd128;
         r_ovf = 1'b1;
      end
      r_fin = r_sat;
      if (RELU != 0 && r_sat[7]) r_fin = 8'sd0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_IN; i++) weight[i] <= '0;
         bias      <= '0;
         acc       <= '0;
         cnt       <= '0;
         cfg_err   <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ovf   <= 1'b0;
      end else begin
         cfg_err <= cfg_we && !cfg_ok;
         if (cfg_ok) begin
            if (cfg_bias) bias <= cfg_data;
            else          weight[cfg_addr] <= cfg_data;
         end

         if (state == IDLE && accept) begin
            acc <= prod_ext;
            cnt <= (N_IN == 1) ? '0 : AW'(1);
         end else if (state == ACC && accept) begin
            acc <= acc + prod_ext;
            cnt <= last ? '0 : cnt + AW'(1);
         end

         if (state == FIN) begin
            out_data <= r_fin;
            out_ovf  <= r_ovf;
         end

         // out_valid rises one cycle into OUT, giving a two-cycle result latency
         if (state == OUT) begin
            if (!out_valid)     out_valid <= 1'b1;
            else if (out_ready) begin
               out_valid <= 1'b0;
               cnt       <= '0;
            end
         end
      end
   end

endmodule
